mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory controller directly downstream of the mem stage, and also serving instruction fetch.
- Arbitrates the mem stage's load/store requests and the IF stage's fetch requests onto a single byte-wide synchronous RAM port.
- Serialises each 1/2/4-byte access into consecutive byte cycles, assembles read data little-endian, and reports per-requester status (Init/Busy/Done).
- The mem stage stalls on this status.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.
- DATA_WIDTH, 32, width of assembled request data; max access = DATA_WIDTH/8 bytes.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-low (rst==0 resets on posedge clk).
- mem_addr_i  input  ADDR_WIDTH  mem-stage byte address.
- mem_wdata_i  input  DATA_WIDTH  mem-stage store data; byte 0 = bits [7:0].
- mem_times_i  input  3  mem-stage byte count (3'b001, 3'b010, 3'b100).
- mem_readwrite_i  input  2  2'b01 read, 2'b10 write, 2'b00/2'b11 no request.
- mem_rdata_o  output  DATA_WIDTH  assembled load data, zero-filled above the byte count.
- mem_status_o  output  2  mem-side status: Init=2'b00, Busy=2'b01, Done=2'b10.
- if_req_i  input  1  fetch request, always 4 bytes.
- if_addr_i  input  ADDR_WIDTH  fetch byte address.
- if_inst_o  output  32  assembled instruction.
- if_status_o  output  2  fetch-side status, same encoding.
- ram_din  input  8  RAM read byte; valid the cycle after its address is driven.
- ram_dout  output  8  RAM write byte.
- ram_a  output  ADDR_WIDTH  RAM byte address.
- ram_wr  output  1  1 = write, 0 = read.

Behaviour:
- All outputs are registered. Reset and idle values: mem_rdata_o=0, if_inst_o=0, both statuses Init, ram_a=0, ram_dout=0, ram_wr=0.
- States: IDLE, READ, WRITE, DONE.
- Request acceptance (IDLE only):
  - Byte count N: mem_times_i[2] → 4; else [1] → 2; else 1. IF fetches are always N=4.
  - Priority: a mem request (readwrite 01/10) beats if_req_i.
  - Accepted requester's status goes to Busy. The other requester stays Init.
  - Address, write data, N and requester are latched at acceptance; inputs are ignored afterwards until IDLE.
- Timing for a request present in IDLE at cycle 0:
  - Cycles 1..N drive ram_a = addr+i, for i = 0..N-1.
  - READ: ram_wr=0. Byte i is sampled from ram_din at the end of cycle i+2 into result bits [8i+7:8i]; upper bytes are 0. Done in cycle N+2 (LW: cycle 6, LB: cycle 3).
  - WRITE: ram_wr=1, ram_dout = wdata[8i+7:8i] in cycle i+1. Done in cycle N+1 (SW: cycle 5, SB: cycle 2). ram_wr returns to 0 in cycle N+1.
  - Between bursts, ram_a and ram_dout hold their last values and ram_wr=0.
- DONE state:
  - Lasts exactly one cycle. Requester status = Done; mem_rdata_o / if_inst_o hold the result.
  - Next cycle: status Init, state IDLE. Requests present during DONE are not accepted. Result outputs keep their value until the next completion for that requester.
- Arithmetic: addr+i wraps modulo 2^ADDR_WIDTH. Address 0xFFFFFFFF with N=2 accesses 0xFFFFFFFF, then 0x0.
- A request withdrawn mid-burst (readwrite→00 or if_req_i→0) does not abort the burst. Done is still produced.
- Reset mid-burst: next cycle state IDLE, all outputs at reset values, no further RAM writes issued.
- An IF fetch waiting during a mem burst starts on the cycle after DONE if still requested (earliest acceptance: cycle DONE+1).

Test Plan:
- LW, addr 0x100, RAM[0x100..0x103]=11,22,33,44 → ram_a 0x100..0x103 in cycles 1–4, mem_status Busy cycles 1–5, Done cycle 6 only, mem_rdata_o=0x44332211, Init cycle 7.
- SH, addr 0x200, wdata 0xDEADBEEF → cycle 1: ram_wr=1, a=0x200, dout=0xEF; cycle 2: a=0x201, dout=0xBE; Done cycle 3; RAM[0x202] unchanged.
- Simultaneous LB addr 0x10 (RAM=0x80) and if_req_i addr 0x0 → mem served first, mem_rdata_o=0x00000080 at cycle 3 with if_status_o=Init throughout; IF accepted at cycle 4, if_inst_o valid with Done at cycle 10.
- LH at addr 0xFFFFFFFF, RAM[0xFFFFFFFF]=0xAA, RAM[0]=0xBB → ram_a 0xFFFFFFFF then 0x0; result 0x0000BBAA.
- rst=0 asserted in cycle 2 of an SW → cycle 3: ram_wr=0, statuses Init; RAM[addr+2], RAM[addr+3] not written.
- Request held high through DONE → no re-acceptance in the DONE cycle; a second identical burst starts at DONE+1 with ram_a=addr in DONE+2.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bundles the mem-stage, fetch and byte-wide RAM signals seen by mem_ctrl.
// slave: the controller side. master: pipeline stages plus RAM.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [DATA_WIDTH-1:0] mem_wdata_i;
  logic [2:0]            mem_times_i;
  logic [1:0]            mem_readwrite_i;
  logic [DATA_WIDTH-1:0] mem_rdata_o;
  logic [1:0]            mem_status_o;
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [31:0]           if_inst_o;
  logic [1:0]            if_status_o;
  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;

  modport slave (
    input  mem_addr_i, mem_wdata_i, mem_times_i, mem_readwrite_i,
    input  if_req_i, if_addr_i, ram_din,
    output mem_rdata_o, mem_status_o, if_inst_o, if_status_o,
    output ram_dout, ram_a, ram_wr
  );

  modport master (
    output mem_addr_i, mem_wdata_i, mem_times_i, mem_readwrite_i,
    output if_req_i, if_addr_i, ram_din,
    input  mem_rdata_o, mem_status_o, if_inst_o, if_status_o,
    input  ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates mem-stage loads/stores (priority) and
// instruction fetches onto one byte-wide synchronous RAM port, serialising
// each access into byte cycles and assembling read data little-endian.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } status_t;

  state_t                state_q;
  status_t               mem_status_q;
  status_t               if_status_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] ram_a_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [31:0]           inst_q;
  logic [31:0]           buf_q;
  logic [2:0]            nbytes_q;
  logic [2:0]            cnt_q;
  logic                  is_if_q;
  logic                  ram_wr_q;
  logic [7:0]            ram_dout_q;

  logic                  mem_rd_req;
  logic                  mem_wr_req;
  logic [2:0]            mem_nbytes;
  logic [2:0]            cnt_inc;
  logic [1:0]            rd_idx;
  logic [1:0]            wr_idx;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0]           asm_data;

  // Request decode, next byte address and the read buffer with the
  // byte arriving this cycle merged in.
  always_comb begin
    mem_rd_req = (bus.mem_readwrite_i == 2'b01);
    mem_wr_req = (bus.mem_readwrite_i == 2'b10);
    case (bus.mem_times_i)
      3'b000, 3'b001: mem_nbytes = 3'd1;
      3'b010, 3'b011: mem_nbytes = 3'd2;
      default:        mem_nbytes = 3'd4;
    endcase
    cnt_inc   = cnt_q + 3'd1;
    // cnt_q counts cycles spent in READ/WRITE; the RAM answers one cycle
    // after the address, so the byte landing now is index cnt_q-1.
    rd_idx    = cnt_q[1:0] - 2'd1;
    wr_idx    = cnt_inc[1:0];
    next_addr = addr_q + ADDR_WIDTH'(cnt_inc);
    asm_data  = buf_q;
    asm_data[8*rd_idx +: 8] = bus.ram_din;
  end

  // Controller FSM with all bus and RAM outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_status_q <= ST_INIT;
      if_status_q  <= ST_INIT;
      addr_q       <= '0;
      ram_a_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      inst_q       <= '0;
      buf_q        <= '0;
      nbytes_q     <= '0;
      cnt_q        <= '0;
      is_if_q      <= 1'b0;
      ram_wr_q     <= 1'b0;
      ram_dout_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          buf_q <= '0;
          if (mem_rd_req || mem_wr_req) begin
            addr_q       <= bus.mem_addr_i;
            wdata_q      <= bus.mem_wdata_i;
            nbytes_q     <= mem_nbytes;
            is_if_q      <= 1'b0;
            ram_a_q      <= bus.mem_addr_i;
            mem_status_q <= ST_BUSY;
            if (mem_wr_req) begin
              state_q    <= WRITE;
              ram_wr_q   <= 1'b1;
              ram_dout_q <= bus.mem_wdata_i[7:0];
            end else begin
              state_q    <= READ;
            end
          end else if (bus.if_req_i) begin
            addr_q      <= bus.if_addr_i;
            nbytes_q    <= 3'd4;
            is_if_q     <= 1'b1;
            ram_a_q     <= bus.if_addr_i;
            if_status_q <= ST_BUSY;
            state_q     <= READ;
          end
        end

        READ: begin
          cnt_q <= cnt_inc;
          if (cnt_q != 3'd0) begin
            buf_q <= asm_data;
          end
          if (cnt_inc < nbytes_q) begin
            ram_a_q <= next_addr;
          end
          if (cnt_q == nbytes_q) begin
            state_q <= DONE;
            if (is_if_q) begin
              inst_q      <= asm_data;
              if_status_q <= ST_DONE;
            end else begin
              rdata_q      <= DATA_WIDTH'(asm_data);
              mem_status_q <= ST_DONE;
            end
          end
        end

        WRITE: begin
          cnt_q <= cnt_inc;
          if (cnt_inc < nbytes_q) begin
            ram_a_q    <= next_addr;
            ram_dout_q <= wdata_q[8*wr_idx +: 8];
          end else begin
            ram_wr_q     <= 1'b0;
            mem_status_q <= ST_DONE;
            state_q      <= DONE;
          end
        end

        DONE: begin
          mem_status_q <= ST_INIT;
          if_status_q  <= ST_INIT;
          state_q      <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_rdata_o  = rdata_q;
  assign bus.mem_status_o = mem_status_q;
  assign bus.if_inst_o    = inst_q;
  assign bus.if_status_o  = if_status_q;
  assign bus.ram_a        = ram_a_q;
  assign bus.ram_dout     = ram_dout_q;
  assign bus.ram_wr       = ram_wr_q;

endmodule
